// File: rtl/mem_responder_256x8_if.sv
// CPU memory bus between the control-unit initiator and the clocked memory responder.
interface mem_responder_256x8_if;
    logic        MOV;
    logic        ReadWrite;
    logic [2:0]  MS_2_0;
    logic [31:0] DataIn;
    logic [31:0] Address;
    logic        MOC;
    logic [31:0] DataOut;

    modport master (
        output MOV, ReadWrite, MS_2_0, DataIn, Address,
        input  MOC, DataOut
    );

    modport slave (
        input  MOV, ReadWrite, MS_2_0, DataIn, Address,
        output MOC, DataOut
    );
endinterface

// File: rtl/mem_responder_256x8.sv
// Purpose: big-endian byte-addressed memory responder (byte/half/word, optional sign extension).
// Latency: MOC rises WAIT_CYCLES+1 edges after the MOV capture edge.
// Backpressure: MOC held while MOV stays high; one RELEASE cycle before the next capture.
module mem_responder_256x8 #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_responder_256x8_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;
    typedef logic [DEPTH_LOG2-1:0] addr_t;

    typedef struct packed {
        logic        rd;
        logic        sext;
        logic [1:0]  size;
        logic [31:0] wdat;
        addr_t       addr;
    } req_t;

    state_t      state;
    state_t      state_nxt;
    req_t        req;
    logic [3:0]  wait_cnt;
    logic        capture;
    logic        commit;
    logic        wr_en;
    logic [31:0] rd_word;
    logic [31:0] dout_q;
    addr_t       byte_addr [4];
    logic [7:0]  rd_byte   [4];
    logic        addr_hi_unused;

    logic [7:0]  memory [DEPTH];

    assign addr_hi_unused = ^bus.Address[31:DEPTH_LOG2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.MOV) begin
                    capture   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bus.MOV) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // MOC is decoded from state so an async reset drops it immediately.
    assign bus.MOC     = (state == DONE);
    assign bus.DataOut = dout_q;
    assign wr_en       = commit && !req.rd;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req      <= '0;
            wait_cnt <= 4'd0;
        end else if (capture) begin
            req.rd   <= bus.ReadWrite;
            req.sext <= bus.MS_2_0[2];
            req.size <= bus.MS_2_0[1:0];
            req.wdat <= bus.DataIn;
            req.addr <= bus.Address[DEPTH_LOG2-1:0];
            wait_cnt <= 4'(WAIT_CYCLES);
        end else if (state == BUSY && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Byte lanes wrap around the top of storage, so unaligned accesses need no special case.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_addr[i] = req.addr + addr_t'(i);
            rd_byte[i]   = memory[byte_addr[i]];
        end
    end

    always_comb begin
        rd_word = '0;
        case (req.size)
            2'b00:   rd_word = {{24{req.sext & rd_byte[0][7]}}, rd_byte[0]};
            2'b01:   rd_word = {{16{req.sext & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
            2'b10:   rd_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= '0;
        end else if (commit) begin
            dout_q <= req.rd ? rd_word : 32'd0;
        end
    end

    // Storage is deliberately left out of reset so contents survive an aborted or completed access.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            case (req.size)
                2'b00: begin
                    memory[byte_addr[0]] <= req.wdat[7:0];
                end
                2'b01: begin
                    memory[byte_addr[0]] <= req.wdat[15:8];
                    memory[byte_addr[1]] <= req.wdat[7:0];
                end
                2'b10: begin
                    memory[byte_addr[0]] <= req.wdat[31:24];
                    memory[byte_addr[1]] <= req.wdat[23:16];
                    memory[byte_addr[2]] <= req.wdat[15:8];
                    memory[byte_addr[3]] <= req.wdat[7:0];
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder_256x8.sv
// Bench for mem_responder_256x8: one instance with 2 wait states, one with none, against a byte-array model.
module tb_mem_responder_256x8;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_responder_256x8_if bus2();
    mem_responder_256x8_if bus0();

    mem_responder_256x8 #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));
    mem_responder_256x8 #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl [2][256];
    bit          sel      = 1'b0;
    bit          chk_en   = 1'b0;
    logic        exp_moc  = 1'b0;
    bit          exp_dchk = 1'b0;
    logic [31:0] exp_dout = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        case (size)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int s, input int a, input logic [2:0] ms);
        int          n;
        logic [31:0] v;
        n = nbytes(ms[1:0]);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[s][(a + i) % 256]);
        if (ms[2] && n > 0 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic model_write(input int s, input int a, input logic [2:0] ms, input logic [31:0] din);
        int n;
        n = nbytes(ms[1:0]);
        for (int i = 0; i < n; i++) mdl[s][(a + i) % 256] = din[8*(n-1-i) +: 8];
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit mov, input bit rw, input logic [2:0] ms,
                         input logic [31:0] din, input logic [31:0] addr);
        if (sel) begin
            bus0.MOV = mov; bus0.ReadWrite = rw; bus0.MS_2_0 = ms; bus0.DataIn = din; bus0.Address = addr;
        end else begin
            bus2.MOV = mov; bus2.ReadWrite = rw; bus2.MS_2_0 = ms; bus2.DataIn = din; bus2.Address = addr;
        end
    endtask

    function automatic logic [31:0] dout_sel();
        return sel ? bus0.DataOut : bus2.DataOut;
    endfunction

    // Single compare process: selected DUT follows the expectation, the other stays quiet.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("moc", 32'(sel ? bus0.MOC : bus2.MOC), 32'(exp_moc));
            if (exp_dchk) chk("dataout", dout_sel(), exp_dout);
            chk("other_moc", 32'(sel ? bus2.MOC : bus0.MOC), 32'd0);
        end
    end

    task automatic do_op(input bit rw, input logic [2:0] ms, input logic [31:0] din,
                         input logic [31:0] addr, input int hold, input bit scramble,
                         input bit use_lit, input logic [31:0] lit, input string nm);
        int          w;
        int          s;
        logic [31:0] e;
        w = sel ? 0 : 2;
        s = sel ? 1 : 0;
        drive(1'b1, rw, ms, din, addr);
        exp_moc = 1'b0;
        step();
        if (scramble) drive(1'b1, 1'($urandom_range(1, 0)), 3'($urandom), $urandom, $urandom);
        for (int i = 0; i < w; i++) step();
        if (rw) begin
            e = model_read(s, int'(addr[7:0]), ms);
        end else begin
            e = 32'd0;
            model_write(s, int'(addr[7:0]), ms, din);
        end
        step();
        exp_moc  = 1'b1;
        exp_dout = e;
        exp_dchk = 1'b1;
        if (use_lit) chk(nm, dout_sel(), lit);
        for (int i = 0; i < hold; i++) step();
        drive(1'b0, 1'($urandom_range(1, 0)), 3'($urandom), $urandom, $urandom);
        step();
        exp_moc = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v;
        RST = 1'b1;
        sel = 1'b1; drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        sel = 1'b0; drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 256; i++) begin
            v = (i < 32) ? i : ((i * 7 + 3) % 256);
            dut2.memory[i] <= 8'(v);
            dut0.memory[i] <= 8'(v);
            mdl[0][i] = 8'(v);
            mdl[1][i] = 8'(v);
        end
        repeat (2) step();
        chk("reset_moc2", 32'(bus2.MOC), 32'd0);
        chk("reset_dout2", bus2.DataOut, 32'd0);
        chk("reset_moc0", 32'(bus0.MOC), 32'd0);
        chk("reset_dout0", bus0.DataOut, 32'd0);
        RST = 1'b0;
        step();
        exp_moc = 1'b0; exp_dout = 32'd0; exp_dchk = 1'b1; chk_en = 1'b1;

        do_op(1'b1, 3'b000, 32'd0, 32'd5,  0, 1'b0, 1'b1, 32'h0000_0005, "rd_byte5");
        do_op(1'b1, 3'b001, 32'd0, 32'd14, 1, 1'b0, 1'b1, 32'h0000_0E0F, "rd_half14");
        do_op(1'b1, 3'b010, 32'd0, 32'd18, 0, 1'b0, 1'b1, 32'h1213_1415, "rd_word18");

        do_op(1'b0, 3'b000, 32'h0000_00FF, 32'd0,  0, 1'b0, 1'b1, 32'd0, "wr_byte0");
        do_op(1'b0, 3'b001, 32'h0000_FFFF, 32'd10, 0, 1'b0, 1'b1, 32'd0, "wr_half10");
        do_op(1'b1, 3'b010, 32'd0, 32'd0,  0, 1'b0, 1'b1, 32'hFF01_0203, "rd_word0");
        do_op(1'b1, 3'b001, 32'd0, 32'd10, 0, 1'b0, 1'b1, 32'h0000_FFFF, "rd_half10_z");
        do_op(1'b1, 3'b101, 32'd0, 32'd10, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, "rd_half10_s");
        do_op(1'b1, 3'b100, 32'd0, 32'd0,  0, 1'b0, 1'b1, 32'hFFFF_FFFF, "rd_byte0_s");

        do_op(1'b0, 3'b010, 32'hC000_0001, 32'd13,  0, 1'b0, 1'b0, 32'd0, "wr_word13");
        do_op(1'b0, 3'b010, 32'hAABB_CCDD, 32'd254, 0, 1'b0, 1'b0, 32'd0, "wr_word254");
        do_op(1'b1, 3'b000, 32'd0, 32'd13,  0, 1'b0, 1'b1, 32'h0000_00C0, "rd_b13");
        do_op(1'b1, 3'b000, 32'd0, 32'd16,  0, 1'b0, 1'b1, 32'h0000_0001, "rd_b16");
        do_op(1'b1, 3'b000, 32'd0, 32'd254, 0, 1'b0, 1'b1, 32'h0000_00AA, "rd_b254");
        do_op(1'b1, 3'b000, 32'd0, 32'd255, 0, 1'b0, 1'b1, 32'h0000_00BB, "rd_b255");
        do_op(1'b1, 3'b000, 32'd0, 32'd0,   0, 1'b0, 1'b1, 32'h0000_00CC, "rd_b0");
        do_op(1'b1, 3'b000, 32'd0, 32'd1,   0, 1'b0, 1'b1, 32'h0000_00DD, "rd_b1");

        // Reset while the write to 40 is still waiting: storage must be untouched.
        drive(1'b1, 1'b0, 3'b010, 32'h1122_3344, 32'd40);
        step();
        step();
        chk_en = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_busy_moc", 32'(bus2.MOC), 32'd0);
        chk("rst_busy_dout", bus2.DataOut, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step();
        RST = 1'b0;
        step();
        exp_moc = 1'b0; exp_dout = 32'd0; exp_dchk = 1'b1; chk_en = 1'b1;
        step();
        do_op(1'b1, 3'b010, 32'd0, 32'd40, 0, 1'b0, 1'b1, 32'h1B22_2930, "rd_word40_after_abort");

        // Reset once the write to 60 has committed: the data must survive.
        drive(1'b1, 1'b0, 3'b010, 32'h5566_7788, 32'd60);
        step(); step(); step();
        model_write(0, 60, 3'b010, 32'h5566_7788);
        step();
        exp_moc = 1'b1; exp_dout = 32'd0;
        chk("done_moc", 32'(bus2.MOC), 32'd1);
        chk_en = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_done_moc", 32'(bus2.MOC), 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step();
        RST = 1'b0;
        step();
        exp_moc = 1'b0; exp_dout = 32'd0; exp_dchk = 1'b1; chk_en = 1'b1;
        step();
        do_op(1'b1, 3'b010, 32'd0, 32'd60, 0, 1'b0, 1'b1, 32'h5566_7788, "rd_word60_after_rst");

        // Long MOC hold with the request inputs scrambled after capture.
        do_op(1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0000_1164, 10, 1'b1, 1'b0, 32'd0, "wr_scramble");
        do_op(1'b1, 3'b010, 32'd0, 32'd100, 10, 1'b1, 1'b1, 32'hDEAD_BEEF, "rd_scramble");

        // Reserved size: no storage change, zero data.
        do_op(1'b0, 3'b011, 32'h1234_5678, 32'd100, 0, 1'b0, 1'b0, 32'd0, "wr_reserved");
        do_op(1'b1, 3'b111, 32'd0, 32'd100, 0, 1'b0, 1'b1, 32'd0, "rd_reserved");
        do_op(1'b1, 3'b010, 32'd0, 32'd100, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd_after_reserved");

        for (int k = 0; k < 60; k++) begin
            do_op(1'($urandom_range(1, 0)), 3'($urandom), $urandom, $urandom,
                  int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0, 32'd0, "rand2");
        end

        sel = 1'b1;
        exp_dchk = 1'b0;
        step();
        do_op(1'b1, 3'b000, 32'd0, 32'd5, 0, 1'b0, 1'b1, 32'h0000_0005, "w0_rd_byte5");
        do_op(1'b0, 3'b010, 32'hAABB_CCDD, 32'd254, 2, 1'b0, 1'b0, 32'd0, "w0_wr_word254");
        do_op(1'b1, 3'b101, 32'd0, 32'd255, 0, 1'b0, 1'b1, 32'hFFFF_BBCC, "w0_rd_half255_s");
        for (int k = 0; k < 30; k++) begin
            do_op(1'($urandom_range(1, 0)), 3'($urandom), $urandom, $urandom,
                  int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0, 32'd0, "rand0");
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder_256x8.md
Name: mem_responder_256x8

Overview:
Clocked memory-side responder for the CPU memory interface (MOV/ReadWrite/MS/Address in, MOC/DataOut out). The block owns 256 bytes of big-endian, byte-addressed storage. It accepts one request per MOV handshake and applies a parameterised wait-state delay. It performs byte, halfword or word reads and writes, with optional sign extension on reads, and returns MOC. It sits between the control-unit FSM and the datapath MDR, replacing the combinational RAM model on the clocked top level.

Parameters:
WAIT_CYCLES, 2, busy cycles between request capture and commit/response (legal 0..15)
DEPTH_LOG2, 8, address bits used; storage = 2**DEPTH_LOG2 bytes

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
MOV  input  1  memory operation valid; held high by initiator until MOC seen
ReadWrite  input  1  1 = read, 0 = write
MS_2_0  input  3  [1:0] size: 00 byte, 01 halfword, 10 word, 11 reserved; [2] = 1 sign-extend read
DataIn  input  32  write data, right-justified (byte in [7:0], half in [15:0])
Address  input  32  byte address; only [DEPTH_LOG2-1:0] used
MOC  output  1  memory operation complete
DataOut  output  32  read data, valid while MOC=1

Behaviour:
- Reset (async, RST=1): state IDLE, MOC=0, DataOut=0, wait counter=0, latched request cleared. Storage contents are NOT reset; the bench preloads them hierarchically via the array named memory.
- FSM states: IDLE, BUSY, DONE, RELEASE.
- IDLE: when MOV=1 at a rising edge, latch ReadWrite, MS_2_0, DataIn and Address[7:0]; load counter=WAIT_CYCLES; go to BUSY. Request inputs are ignored outside IDLE; later changes have no effect.
- BUSY: the counter decrements each cycle. When it is 0, commit the access and go to DONE. With WAIT_CYCLES=0, BUSY lasts exactly 1 cycle.
- Latency: MOV sampled high at edge N; MOC=1 after edge N+WAIT_CYCLES+1 (default: 3 edges after capture).
- Commit, write: store bytes big-endian starting at the latched address A. Word: DataIn[31:24]->A, [23:16]->A+1, [15:8]->A+2, [7:0]->A+3. Half: [15:8]->A, [7:0]->A+1. Byte: [7:0]->A. DataOut=0.
- Commit, read: assemble the same byte order right-justified into DataOut.
  - MS[2]=0: zero-extend.
  - MS[2]=1: sign-extend from bit 7 (byte) or bit 15 (half).
  - MS[2] has no effect on word reads.
- Alignment: unaligned addresses are legal. Byte offsets wrap modulo 256 (word at 254 uses 254, 255, 0, 1).
- Reserved size 11: no storage write; DataOut=0; handshake completes normally.
- DONE: MOC=1, DataOut held stable. Stay while MOV=1. When MOV=0 at an edge, go to RELEASE with MOC=0.
- RELEASE: one idle cycle, MOC=0, DataOut retains the last value. Return to IDLE. A new MOV is not accepted until IDLE, so the minimum gap between captures is WAIT_CYCLES+4 cycles.
- Back-to-back: if MOV stays high through RELEASE, a new request is captured in IDLE on the following edge.
- Reset mid-operation:
  - RST in BUSY aborts the access; no bytes are written.
  - RST in DONE or RELEASE leaves the committed write intact.
  - MOC drops immediately (asynchronously).
- Write then read of the same address with no intervening reset must return the written data.
- No X propagation: DataOut is never X after reset, and unwritten bytes read as whatever was preloaded.

Test Plan:
- Preload bytes 0..31 with the value = address. Byte read, addr 5, MS=000 -> MOC rises 3 cycles after capture, DataOut=0x00000005; MOV low -> MOC low the next edge.
- Half read at addr 14, MS=001 -> DataOut=0x00000E0F. Word read at addr 18, MS=010 -> 0x12131415.
- Write byte 0xFF at addr 0 (DataIn=0x000000FF, MS=000) and half 0xFFFF at addr 10. Then read a word at 0 -> 0xFF010203; read a half at 10 -> 0x0000FFFF. Read a half at 10 with MS=101 -> 0xFFFFFFFF; byte at 0 with MS=100 -> 0xFFFFFFFF.
- Write word 0xC0000001 at addr 13, then word write 0xAABBCCDD at addr 254 -> byte reads return 13:0xC0, 16:0x01, 254:0xAA, 255:0xBB, 0:0xCC, 1:0xDD.
- Word write 0x11223344 at addr 40 with RST pulsed during BUSY -> MOC=0 immediately, FSM in IDLE; word read at 40 returns the preloaded value, unchanged.
- MOV held high for 10 cycles in DONE, and DataIn/Address changed during BUSY -> MOC stays 1 and DataOut stays stable; the committed access uses the captured values. Rerun with WAIT_CYCLES=0 -> MOC rises 1 cycle after capture.
